// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the 64x4 SRAM request controller.
package sram_ctrl_pkg;

  localparam int SRAM_ADDR_WIDTH  = 6;
  localparam int SRAM_DATA_WIDTH  = 4;
  localparam int SRAM_WMASK_WIDTH = 2;
  localparam int SRAM_DEPTH       = 1 << SRAM_ADDR_WIDTH;

  // Controller phases: one boot cycle, optional array clear, then normal traffic.
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Small synchronous response FIFO with asynchronous reset. Head data is
// always driven from storage, so an empty FIFO shows the last head (never X).
module sram_rsp_fifo #(
  parameter int DATA_WIDTH = 4,
  parameter int RSP_DEPTH  = 2,
  localparam int CW = $clog2(RSP_DEPTH + 1),
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] pop_data_o,
  output logic [CW-1:0]         count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic                  do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o     = (count_q == CW'(RSP_DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign do_push    = push_i & ~full_o;
  assign do_pop     = pop_i & ~empty_o;

  // Storage, pointers and occupancy; simultaneous push+pop leaves count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RSP_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sram_64x4_req_ctrl.sv
// Request front-end for the 64x4 SRAM macro: optional post-reset clear,
// combinational pin drive from accepted requests, and a credit-limited
// response FIFO so read data is never dropped.
module sram_64x4_req_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = SRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH  = SRAM_DATA_WIDTH,
  parameter int WMASK_WIDTH = SRAM_WMASK_WIDTH,
  parameter int RSP_DEPTH   = 2,
  parameter bit INIT_CLEAR  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [WMASK_WIDTH-1:0] req_wmask,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]  req_din,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_WIDTH-1:0]  rsp_data,
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout,
  output logic                   init_done
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam logic [CW:0] CREDITS = (CW + 1)'(RSP_DEPTH);

  state_e               state_q, state_d;
  logic [ADDR_WIDTH:0]  clr_addr_q, clr_addr_d;
  logic                 rd_pend_q, rd_pend_d;
  logic [CW-1:0]        fifo_count;
  logic                 fifo_full, fifo_empty;
  logic [CW:0]          slots_used;
  logic                 fire;

  // A pending read already owns a FIFO slot, so it counts against the credit.
  assign slots_used = {1'b0, fifo_count} + {{CW{1'b0}}, rd_pend_q};
  assign fire       = req_valid & req_ready;
  assign rsp_valid  = ~fifo_empty;

  // State, clear pointer and read-pending flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      clr_addr_q <= '0;
      rd_pend_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      rd_pend_q  <= rd_pend_d;
    end
  end

  // Next state and macro pin drive; the clear ends when the pointer MSB sets.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    rd_pend_d  = 1'b0;
    req_ready  = 1'b0;
    sram_we    = 1'b0;
    sram_wmask = '0;
    sram_addr  = '0;
    sram_din   = '0;
    init_done  = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d = INIT_CLEAR ? ST_CLEAR : ST_RUN;
      end
      ST_CLEAR: begin
        sram_we    = 1'b1;
        sram_wmask = '1;
        sram_addr  = clr_addr_q[ADDR_WIDTH-1:0];
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_d[ADDR_WIDTH]) state_d = ST_RUN;
      end
      ST_RUN: begin
        init_done  = 1'b1;
        req_ready  = ~fifo_full && (slots_used < CREDITS);
        sram_addr  = req_addr;
        sram_din   = req_din;
        sram_we    = req_valid & req_ready & req_we;
        sram_wmask = (req_valid & req_ready) ? req_wmask : '0;
        rd_pend_d  = req_valid & req_ready & ~req_we;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  sram_rsp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .RSP_DEPTH  (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (rd_pend_q),
    .push_data_i (sram_dout),
    .pop_i       (rsp_ready),
    .pop_data_o  (rsp_data),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // fire is only meaningful in RUN; kept as a named net for waveform readability.
  logic unused_fire;
  assign unused_fire = fire;

endmodule
